tx_word_serializer: RTL and testbench

UART-style transmit stage for the MxV result path. Accepts one 16-bit result word on a START request, sends it as two back-to-back 8N1 frames (high byte first), then emits a one-cycle TX_DONE. TX_DONE drives the upstream capture control unit's PULSE input, so that unit advances exactly one capture slot per transmitted word.

---
 rtl/tx_pkg.sv | 33 +++
 rtl/baud_tick_gen.sv | 31 +++
 rtl/tx_word_serializer.sv | 138 +++++++++++++
 tb/tb_tx_word_serializer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared state type and frame constants for the word serializer.
// Defining TX_PARITY_EN adds the PARITY_BIT state (8E1 frames instead of 8N1).
package tx_pkg;

  localparam int unsigned FRAME_DATA_BITS  = 8;
  localparam int unsigned STOP_BITS        = 1;
  localparam int unsigned BAUD_DIV_DEFAULT = 434;

`ifdef TX_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    PARITY_BIT,
    STOP_BIT
  } tx_state_t;
`else
  localparam int unsigned PARITY_BITS = 0;
  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } tx_state_t;
`endif

  // Serial bit periods per frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits();
    return 1 + FRAME_DATA_BITS + PARITY_BITS + STOP_BITS;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..BAUD_DIV-1 and flags the last cycle of each bit.
// A synchronous clear realigns the period to the cycle after the clearing edge.
module baud_tick_gen
  import tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick_c = (cnt_q == LAST);

endmodule

// File: rtl/tx_word_serializer.sv
// Sends a DATA_W-bit word as back-to-back UART frames, most significant byte first,
// then pulses TX_DONE for one cycle. TX_PARITY_EN adds an even-parity bit per frame.
module tx_word_serializer
  import tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              START,
  input  logic [DATA_W-1:0] DATA,
  output logic              TX,
  output logic              BUSY,
  output logic              TX_DONE
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned BIT_W  = 3;

  tx_state_t         state_q, state_n;
  logic [DATA_W-1:0] shreg_q, shreg_n;
  logic [BIT_W-1:0]  bit_q, bit_n;
  logic [BYTE_W-1:0] byte_q, byte_n;
  logic              tx_n, busy_n, done_n;
  logic              tick_c, clear_c;
  logic [7:0]        cur_byte;

  // The byte on the wire always sits in the top of the shift register.
  assign cur_byte = shreg_q[DATA_W-1 -: 8];

  baud_tick_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (clear_c),
    .tick_c(tick_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state plus the next value of every registered output.
  always_comb begin
    state_n = state_q;
    shreg_n = shreg_q;
    bit_n   = bit_q;
    byte_n  = byte_q;
    tx_n    = 1'b1;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_n = START_BIT;
          shreg_n = DATA;
          byte_n  = '0;
          tx_n    = 1'b0;
        end
      end
      START_BIT: begin
        tx_n = 1'b0;
        if (tick_c) begin
          state_n = DATA_BITS;
          bit_n   = '0;
          tx_n    = cur_byte[0];
        end
      end
      DATA_BITS: begin
        tx_n = cur_byte[bit_q];
        if (tick_c) begin
          if (bit_q == BIT_W'(FRAME_DATA_BITS - 1)) begin
`ifdef TX_PARITY_EN
            state_n = PARITY_BIT;
            tx_n    = ^cur_byte;
`else
            state_n = STOP_BIT;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n = bit_q + BIT_W'(1);
            tx_n  = cur_byte[bit_q + BIT_W'(1)];
          end
        end
      end
`ifdef TX_PARITY_EN
      PARITY_BIT: begin
        tx_n = ^cur_byte;
        if (tick_c) begin
          state_n = STOP_BIT;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP_BIT: begin
        if (tick_c) begin
          if (byte_q != BYTE_W'(NBYTES - 1)) begin
            state_n = START_BIT;
            byte_n  = byte_q + BYTE_W'(1);
            shreg_n = shreg_q << 8;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n  = (state_n != IDLE);
    clear_c = (state_n != state_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      TX      <= 1'b1;
      BUSY    <= 1'b0;
      TX_DONE <= 1'b0;
    end else begin
      shreg_q <= shreg_n;
      bit_q   <= bit_n;
      byte_q  <= byte_n;
      TX      <= tx_n;
      BUSY    <= busy_n;
      TX_DONE <= done_n;
    end
  end

endmodule

// File: tb/tb_tx_word_serializer.sv
// Self-checking bench for tx_word_serializer: a waveform-queue model predicts TX/BUSY/TX_DONE
// every cycle; directed tests pin the model with literal bit patterns and timings.
module tb_tx_word_serializer;

  localparam int BD = 4;
`ifdef TX_PARITY_EN
  localparam int FB = 11;
  localparam logic [15:0] T2_DATA = 16'h0700;
`else
  localparam int FB = 10;
  localparam logic [15:0] T2_DATA = 16'hA55A;
`endif
  localparam int NB   = 2 * FB;
  localparam int WORD = NB * BD;

  logic        clk = 1'b0;
  logic        reset;
  logic        START;
  logic [15:0] DATA;
  logic        TX, BUSY, TX_DONE;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  logic q[$];
  logic m_done = 1'b0;

  tx_word_serializer #(
    .BAUD_DIV(BD),
    .DATA_W  (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .START  (START),
    .DATA   (DATA),
    .TX     (TX),
    .BUSY   (BUSY),
    .TX_DONE(TX_DONE)
  );

  always #5 clk = ~clk;

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_bits(input logic v);
    repeat (BD) q.push_back(v);
  endtask

  // Line waveform of one word: per byte (MSB byte first) start, 8 data LSB first, [parity], stop.
  task automatic push_word(input logic [15:0] w);
    for (int b = 1; b >= 0; b--) begin
      logic [7:0] by;
      by = w[b*8 +: 8];
      push_bits(1'b0);
      for (int i = 0; i < 8; i++) push_bits(by[i]);
`ifdef TX_PARITY_EN
      push_bits(^by);
`endif
      push_bits(1'b1);
    end
  endtask

  // Model: queue holds the remaining line samples of the word in flight.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (q.size() != 0) begin
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1'b1;
      end else if (START) begin
        push_word(DATA);
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk_bit("tx", TX, (q.size() != 0) ? q[0] : 1'b1);
      chk_bit("busy", BUSY, q.size() != 0);
      chk_bit("tx_done", TX_DONE, m_done);
    end
  end

  initial begin
    logic [0:NB-1] exp_bits;
    int ndone, done_at, prev;

`ifdef TX_PARITY_EN
    exp_bits = 22'b01110000011_00000000001;
`else
    exp_bits = 20'b0101001011_0010110101;
`endif
    reset = 1'b0;
    START = 1'b0;
    DATA  = '0;
    repeat (3) @(negedge clk);
    reset    = 1'b1;
    check_en = 1;

    // Idle after reset
    repeat (100) @(negedge clk);
    chk_bit("idle_tx", TX, 1'b1);
    chk_bit("idle_busy", BUSY, 1'b0);
    chk_bit("idle_done", TX_DONE, 1'b0);

    // Single word with literal line pattern
    START = 1'b1;
    DATA  = T2_DATA;
    @(negedge clk);
    START = 1'b0;
    chk_bit("accept_tx", TX, 1'b0);
    chk_bit("accept_busy", BUSY, 1'b1);
    ndone = 0;
    done_at = -1;
    for (int c = 0; c < WORD + 16; c++) begin
      if ((c % BD) == 2 && (c / BD) < NB) chk_bit($sformatf("bit%0d", c / BD), TX, exp_bits[c / BD]);
      if (TX_DONE) begin
        ndone++;
        done_at = c;
      end
      @(negedge clk);
    end
    chk_int("t2_done_count", ndone, 1);
    chk_int("t2_done_cycle", done_at, WORD);

    // START pulsed while busy is ignored
    START = 1'b1;
    DATA  = 16'h1234;
    @(negedge clk);
    ndone = 0;
    done_at = -1;
    for (int c = 0; c < WORD + 20; c++) begin
      START = (c < WORD - 10) && ((c % 3) == 0);
      DATA  = 16'hFFFF;
      if (TX_DONE) begin
        ndone++;
        done_at = c;
      end
      @(negedge clk);
    end
    START = 1'b0;
    chk_int("t3_done_count", ndone, 1);
    chk_int("t3_done_cycle", done_at, WORD);

    // START held high: back-to-back words
    START = 1'b1;
    DATA  = 16'h3C96;
    @(negedge clk);
    ndone = 0;
    prev = -1;
    for (int c = 0; c < 5 * (WORD + 1) - 5; c++) begin
      if (TX_DONE) begin
        if (prev >= 0) chk_int("b2b_period", c - prev, WORD + 1);
        prev = c;
        ndone++;
      end
      @(negedge clk);
    end
    START = 1'b0;
    chk_int("b2b_count", ndone, 4);
    repeat (WORD + 10) @(negedge clk);

    // Asynchronous reset mid-word
    START = 1'b1;
    DATA  = 16'hC3A5;
    @(negedge clk);
    START = 1'b0;
    repeat (30) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk_bit("rst_tx", TX, 1'b1);
    chk_bit("rst_busy", BUSY, 1'b0);
    chk_bit("rst_done", TX_DONE, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    repeat (WORD) begin
      @(negedge clk);
      if (TX_DONE) ndone++;
    end
    chk_int("rst_no_done", ndone, 0);
    START = 1'b1;
    DATA  = 16'h5AA5;
    @(negedge clk);
    START = 1'b0;
    ndone = 0;
    repeat (WORD + 10) begin
      if (TX_DONE) ndone++;
      @(negedge clk);
    end
    chk_int("rst_restart_done", ndone, 1);

    // Randomized START/DATA traffic against the model
    for (int c = 0; c < 2000; c++) begin
      START = ($urandom_range(0, 7) == 0);
      DATA  = 16'($urandom);
      @(negedge clk);
    end
    START = 1'b0;
    repeat (WORD + 10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
